// File: rtl/display_feeder.sv
// Display producer: converts a binary magnitude to 8 BCD digits with a sequential
// double-dabble engine (or forwards an error/overflow code), then strobes latch once.
module display_feeder #(
   parameter int                BIN_W    = 27,
   parameter logic [BIN_W-1:0]  MAX_VAL  = BIN_W'(99_999_999),
   parameter logic [3:0]        OVF_CODE = 4'h1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [BIN_W-1:0] value,
   input  logic [2:0]       dp_in,
   input  logic             err,
   input  logic [3:0]       err_code,
   output logic             busy,
   output logic             latch,
   output logic             mode,
   output logic [2:0]       dp,
   output logic [3:0]       codes,
   output logic [31:0]      num
);

   localparam int CNT_W = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, EMIT, DONE} state_t;

   state_t             state_q, state_d;
   logic [BIN_W-1:0]   bin_q, bin_d;
   logic [31:0]        bcd_q, bcd_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         dp_cap_q, dp_cap_d;
   logic [3:0]         code_q, code_d;
   logic               is_code_q, is_code_d;
   logic               busy_q, busy_d;
   logic               latch_q, latch_d;
   logic               mode_q, mode_d;
   logic [2:0]         dp_q, dp_d;
   logic [3:0]         codes_q, codes_d;
   logic [31:0]        num_q, num_d;
   logic [31:0]        adj;

   always_comb begin
      state_d   = state_q;
      bin_d     = bin_q;
      bcd_d     = bcd_q;
      cnt_d     = cnt_q;
      dp_cap_d  = dp_cap_q;
      code_d    = code_q;
      is_code_d = is_code_q;
      busy_d    = busy_q;
      latch_d   = latch_q;
      mode_d    = mode_q;
      dp_d      = dp_q;
      codes_d   = codes_q;
      num_d     = num_q;
      adj       = bcd_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               busy_d   = 1'b1;
               bin_d    = value;
               dp_cap_d = dp_in;
               if (err) begin
                  code_d    = err_code;
                  is_code_d = 1'b1;
                  state_d   = EMIT;
               end else if (value > MAX_VAL) begin
                  code_d    = OVF_CODE;
                  is_code_d = 1'b1;
                  state_d   = EMIT;
               end else begin
                  bcd_d     = '0;
                  cnt_d     = '0;
                  is_code_d = 1'b0;
                  state_d   = SHIFT;
               end
            end
         end
         SHIFT: begin
            // add-3 correction keeps each nibble decimal after the following doubling
            for (int i = 0; i < 8; i++) begin
               if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
            {bcd_d, bin_d} = {adj, bin_q} << 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BIN_W - 1)) state_d = EMIT;
         end
         EMIT: begin
            latch_d = 1'b1;
            state_d = DONE;
            if (is_code_q) begin
               mode_d  = 1'b1;
               codes_d = code_q;
               num_d   = '0;
               dp_d    = '0;
            end else begin
               mode_d  = 1'b0;
               codes_d = '0;
               num_d   = bcd_q;
               dp_d    = dp_cap_q;
            end
         end
         DONE: begin
            latch_d = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         bin_q     <= '0;
         bcd_q     <= '0;
         cnt_q     <= '0;
         dp_cap_q  <= '0;
         code_q    <= '0;
         is_code_q <= 1'b0;
         busy_q    <= 1'b0;
         latch_q   <= 1'b0;
         mode_q    <= 1'b0;
         dp_q      <= '0;
         codes_q   <= '0;
         num_q     <= '0;
      end else begin
         state_q   <= state_d;
         bin_q     <= bin_d;
         bcd_q     <= bcd_d;
         cnt_q     <= cnt_d;
         dp_cap_q  <= dp_cap_d;
         code_q    <= code_d;
         is_code_q <= is_code_d;
         busy_q    <= busy_d;
         latch_q   <= latch_d;
         mode_q    <= mode_d;
         dp_q      <= dp_d;
         codes_q   <= codes_d;
         num_q     <= num_d;
      end
   end

   assign busy  = busy_q;
   assign latch = latch_q;
   assign mode  = mode_q;
   assign dp    = dp_q;
   assign codes = codes_q;
   assign num   = num_q;

endmodule

// File: tb/tb_display_feeder.sv
// Randomized and directed bench for display_feeder; expectations come from a decimal
// digit model and are checked by a monitor whenever latch is seen high.
module tb_display_feeder;

   localparam int          BIN_W   = 27;
   localparam int unsigned MAX_VAL = 99_999_999;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic [BIN_W-1:0] value = '0;
   logic [2:0]       dp_in = '0;
   logic             err = 1'b0;
   logic [3:0]       err_code = '0;
   logic             busy, latch, mode;
   logic [2:0]       dp;
   logic [3:0]       codes;
   logic [31:0]      num;

   display_feeder dut (
      .clock(clock), .reset(reset), .start(start), .value(value), .dp_in(dp_in),
      .err(err), .err_code(err_code), .busy(busy), .latch(latch), .mode(mode),
      .dp(dp), .codes(codes), .num(num)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        mode;
      logic [3:0]  codes;
      logic [31:0] num;
      logic [2:0]  dp;
      int          lcyc;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   n_latch  = 0;
   int   n_push   = 0;
   logic prev_latch = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: bound expired at cycle %0d", name, cyc);
   endtask

   function automatic logic [31:0] to_bcd(input int unsigned v);
      logic [31:0] r;
      int unsigned x;
      r = '0;
      x = v;
      for (int i = 0; i < 8; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic issue(input int unsigned v, input logic [2:0] d, input logic e, input logic [3:0] c);
      exp_t x;
      int   t;
      t = 0;
      while (busy !== 1'b0 && t < 200) begin
         @(negedge clock);
         t++;
      end
      if (t >= 200) fail_now("wait_idle");
      start    = 1'b1;
      value    = BIN_W'(v);
      dp_in    = d;
      err      = e;
      err_code = c;
      if (e) begin
         x = '{mode: 1'b1, codes: c, num: 32'h0, dp: 3'd0, lcyc: cyc + 2};
      end else if (v > MAX_VAL) begin
         x = '{mode: 1'b1, codes: 4'h1, num: 32'h0, dp: 3'd0, lcyc: cyc + 2};
      end else begin
         x = '{mode: 1'b0, codes: 4'h0, num: to_bcd(v), dp: d, lcyc: cyc + BIN_W + 2};
      end
      sb.push_back(x);
      n_push++;
      @(negedge clock);
      start = 1'b0;
      err   = 1'b0;
      check("busy_rise", busy, 1);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((sb.size() != 0 || busy !== 1'b0) && t < 200) begin
         @(negedge clock);
         t++;
      end
      if (t >= 200) fail_now("drain");
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},  busy,  0);
      check({tag, "_latch"}, latch, 0);
      check({tag, "_mode"},  mode,  0);
      check({tag, "_dp"},    dp,    0);
      check({tag, "_codes"}, codes, 0);
      check({tag, "_num"},   num,   0);
   endtask

   initial begin
      exp_t x;
      forever begin
         @(negedge clock);
         if (reset) begin
            prev_latch = 1'b0;
         end else begin
            if (prev_latch) begin
               check("latch_one_cycle", latch, 0);
               check("busy_falls_with_latch", busy, 0);
            end
            if (latch === 1'b1) begin
               n_latch++;
               if (sb.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_latch: got num=0x%0h mode=%0d, expected no latch (cycle %0d)",
                           num, mode, cyc);
               end else begin
                  x = sb.pop_front();
                  check("mode",    mode,  x.mode);
                  check("codes",   codes, x.codes);
                  check("num",     num,   x.num);
                  check("dp",      dp,    x.dp);
                  check("latency", cyc,   x.lcyc);
                  check("busy_during_latch", busy, 1);
               end
            end
            prev_latch = latch;
         end
      end
   end

   initial begin
      int t;
      int r;
      int unsigned v;
      repeat (3) @(negedge clock);
      check_reset_outputs("reset");
      reset = 1'b0;
      @(negedge clock);

      issue(0, 3'd0, 1'b0, 4'h0);
      drain();

      issue(12_345_678, 3'd3, 1'b0, 4'h0);
      drain();
      repeat (10) @(negedge clock);
      check("hold_num",   num,   32'h12345678);
      check("hold_dp",    dp,    3);
      check("hold_mode",  mode,  0);
      check("hold_codes", codes, 0);

      issue(99_999_999, 3'd5, 1'b0, 4'h0);
      issue(100_000_000, 3'd2, 1'b0, 4'h0);
      issue(42, 3'd4, 1'b1, 4'h5);
      issue(134_217_727, 3'd1, 1'b1, 4'h9);
      drain();

      // extra starts while busy and at the busy-falling edge must be dropped
      issue(7, 3'd0, 1'b0, 4'h0);
      repeat (8) @(negedge clock);
      start = 1'b1;
      value = BIN_W'(8);
      @(negedge clock);
      start = 1'b0;
      t = 0;
      while (latch !== 1'b1 && t < 100) begin
         @(negedge clock);
         t++;
      end
      if (t >= 100) fail_now("wait_latch");
      start = 1'b1;
      value = BIN_W'(8);
      @(negedge clock);
      start = 1'b0;
      repeat (40) @(negedge clock);
      check("ignored_start_idle", busy, 0);
      check("ignored_start_num", num, 32'h00000007);

      issue(55, 3'd6, 1'b0, 4'h0);
      repeat (9) @(negedge clock);
      reset = 1'b1;
      n_push -= sb.size();
      sb.delete();
      @(negedge clock);
      check_reset_outputs("abort");
      reset = 1'b0;
      repeat (40) @(negedge clock);
      check("abort_no_latch", latch, 0);
      issue(55, 3'd0, 1'b0, 4'h0);
      drain();
      check("after_abort_num", num, 32'h00000055);

      for (int i = 0; i < 30; i++) begin
         r = $urandom_range(0, 7);
         if (r == 1) v = $urandom_range(MAX_VAL + 1, (1 << BIN_W) - 1);
         else if (r == 2) v = MAX_VAL;
         else v = $urandom_range(0, MAX_VAL);
         issue(v, 3'($urandom_range(0, 7)), (r == 0), 4'($urandom_range(0, 15)));
      end
      drain();
      repeat (5) @(negedge clock);
      check("latch_count", n_latch, n_push);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
